qed_inst_constraint_seq: RTL and testbench
==========================================

# qed_inst_constraint_seq

Parametrised, stateful instruction constraint for the SQED harness on the RISC-V core. Classifies each instruction presented to the fetch interface, restricts original-stream register use to the lower register half, and adds sequential limits: a non-NOP instruction budget, a memory-op budget, and a minimum gap between memory ops. Produces a combinational `allowed` flag, optionally drives the formal `assume`, and exposes counters and a registered violation flag for simulation benches.

## Interface
- `NUM_ORIG_REGS`, 16: registers usable by the original stream; power of 2, 2..16; every used rd/rs1/rs2 must be < this.
- `ENABLE_MUL`, 0: 1 also permits MUL/MULH/MULHSU/MULHU (opcode 0110011, funct7 0000001, funct3 000..011).
- `ENABLE_LW`, 1: 1 permits LW.
- `MAX_INSTS`, 32: non-NOP instruction budget, ≥1.
- `MAX_MEM_OPS`, 4: LW+SW budget, ≥0.
- `MEM_GAP`, 2: accepted instructions required after a memory op before the next memory op, ≥0.
- `ASSUME_EN`, 1: 1 emits `assume property (rst || !inst_valid || allowed)` at posedge `clk`.
- `clk` in 1: single clock; all state on posedge.
- `rst` in 1: synchronous, active-high reset.
- `instruction` in 32: candidate instruction.
- `inst_valid` in 1: instruction is issued this cycle.
- `allowed` out 1: combinational legality of `instruction` under the current state.
- `phase` out 2: 0 RUN, 1 COOLDOWN, 2 DRAIN.
- `inst_count` out clog2(MAX_INSTS+1): accepted non-NOP count.
- `mem_count` out clog2(MAX_MEM_OPS+1) (min 1): accepted memory-op count.
- `violation` out 1: registered; high one cycle after a valid, disallowed instruction.

## Operation
- Field decode per RV32I: opcode[6:0], rd[11:7], funct3[14:12], rs1[19:15], rs2[24:20], funct7[31:25].
- Static legality, `static_ok`, is the OR of these classes:
  - I-ALU (0010011): ADDI, SLTI, SLTIU, XORI, ORI, ANDI. SLLI requires funct7 0000000. SRLI/SRAI require funct7 0000000/0100000. rs1, rd < NUM_ORIG_REGS.
  - R-ALU (0110011): ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND with standard funct7. M-ops are included when ENABLE_MUL. rs1, rs2, rd < NUM_ORIG_REGS.
  - LW (0000011, funct3 010) when ENABLE_LW: rs1 == 0, instruction[31:30] == 00, rd < NUM_ORIG_REGS.
  - SW (0100011, funct3 010): rs1 == 0, instruction[31:30] == 00, rs2 < NUM_ORIG_REGS.
  - NOP: opcode 1111111, other bits don't-care.
- Derived state:
  - `exhausted` = (inst_count == MAX_INSTS).
  - `mem_ok` = (mem_count < MAX_MEM_OPS) && (gap_cnt == 0).
- `allowed` = static_ok && (NOP || (!exhausted && (!is_mem || mem_ok))).
- Accept = inst_valid && allowed && !rst. On accept:
  - Non-NOP: inst_count += 1 (cannot exceed MAX_INSTS by construction).
  - Memory op: mem_count += 1, and gap_cnt loads MEM_GAP.
  - Any other accepted instruction, NOPs included: gap_cnt decrements if nonzero.
- inst_valid low, or a disallowed instruction: no counter or gap change.
- `phase` is derived, with priority DRAIN > COOLDOWN > RUN:
  - DRAIN if exhausted; only NOPs are allowed here, and the block stays in DRAIN until reset.
  - COOLDOWN if gap_cnt != 0.
  - RUN otherwise.
- When MAX_MEM_OPS == 0, memory ops are never allowed.
- Reset sets inst_count, mem_count, gap_cnt and violation to 0, so `phase` = RUN.
  - Reset mid-sequence discards all history.
  - The instruction present during the reset cycle is not counted.

## Timing
- `allowed` is combinational from `instruction` and the registered state, with zero latency.
- Counters and gap_cnt update at the posedge where accept is high. They are visible the next cycle.
- `violation` is asserted in cycle N+1 for inst_valid && !allowed in cycle N, and lasts one cycle per event. Back-to-back violations hold it high continuously. It is 0 during and after reset.
- The budget-filling instruction is accepted in cycle N. DRAIN is visible in N+1, where a non-NOP yields allowed = 0.
- Memory op accepted in cycle N with MEM_GAP = 2: a memory op is disallowed until two further accepts have occurred.
- Simultaneous memory-op accept and budget exhaustion: both counters update in the same edge, and DRAIN takes priority.

## Test plan
- Reset, then ADDI x1,x2,5 (0x00510093) with valid → allowed = 1, and inst_count = 1 the next cycle. Then ADDI x17,x2,5 → allowed = 0, and violation = 1 the next cycle.
- ENABLE_MUL = 0: MUL x1,x2,x3 → allowed = 0. With ENABLE_MUL = 1 → allowed = 1. With NUM_ORIG_REGS = 8, ADD x9,x1,x2 → allowed = 0.
- MEM_GAP = 2: SW x1,0(x0) accepted → phase = 1. An immediate LW → allowed = 0. Then NOP, ADDI → phase = 0, and LW → allowed = 1.
- MAX_MEM_OPS = 2, MEM_GAP = 0: SW, SW accepted → mem_count = 2. Third SW → allowed = 0, and mem_count stays 2.
- MAX_INSTS = 3: three ADDIs → phase = 2. Next ADD → allowed = 0, while NOP (0x0000007F) → allowed = 1. inst_count stays 3.
- Assert rst in DRAIN → next cycle all counters = 0, phase = 0, violation = 0. inst_valid low with an illegal instruction → violation stays 0.

Source files
------------

// File: rtl/qed_inst_constraint_seq_if.sv
// Fetch-side bundle for the SQED instruction constraint: candidate instruction
// in, legality verdict plus observable sequencing state out.
interface qed_inst_constraint_seq_if #(
  parameter int MAX_INSTS   = 32,
  parameter int MAX_MEM_OPS = 4
);
  localparam int INST_W = $clog2(MAX_INSTS + 1);
  localparam int MEM_W  = (MAX_MEM_OPS < 1) ? 1 : $clog2(MAX_MEM_OPS + 1);

  logic [31:0]       instruction;
  logic              inst_valid;
  logic              allowed;
  logic [1:0]        phase;
  logic [INST_W-1:0] inst_count;
  logic [MEM_W-1:0]  mem_count;
  logic              violation;

  modport master (
    output instruction, inst_valid,
    input  allowed, phase, inst_count, mem_count, violation
  );

  modport slave (
    input  instruction, inst_valid,
    output allowed, phase, inst_count, mem_count, violation
  );
endinterface

// File: rtl/qed_inst_constraint_seq.sv
// Stateful SQED instruction constraint: static RV32I subset/register-half check
// plus instruction budget, memory-op budget and minimum spacing between memory ops.
module qed_inst_constraint_seq #(
  parameter int NUM_ORIG_REGS = 16,
  parameter bit ENABLE_MUL    = 1'b0,
  parameter bit ENABLE_LW     = 1'b1,
  parameter int MAX_INSTS     = 32,
  parameter int MAX_MEM_OPS   = 4,
  parameter int MEM_GAP       = 2,
  parameter bit ASSUME_EN     = 1'b1
) (
  input logic                      clk,
  input logic                      rst,
  qed_inst_constraint_seq_if.slave bus
);
  localparam int INST_W = $clog2(MAX_INSTS + 1);
  localparam int MEM_W  = (MAX_MEM_OPS < 1) ? 1 : $clog2(MAX_MEM_OPS + 1);
  localparam int GAP_W  = (MEM_GAP < 1) ? 1 : $clog2(MEM_GAP + 1);
  localparam logic [5:0] NREG = 6'(NUM_ORIG_REGS);

  typedef enum logic [1:0] {
    PH_RUN      = 2'd0,
    PH_COOLDOWN = 2'd1,
    PH_DRAIN    = 2'd2
  } phase_e;

  logic [INST_W-1:0] inst_count_q, inst_count_d;
  logic [MEM_W-1:0]  mem_count_q, mem_count_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic              violation_q, violation_d;

  logic [6:0] opcode, funct7;
  logic [4:0] rd, rs1, rs2;
  logic [2:0] funct3;
  assign opcode = bus.instruction[6:0];
  assign rd     = bus.instruction[11:7];
  assign funct3 = bus.instruction[14:12];
  assign rs1    = bus.instruction[19:15];
  assign rs2    = bus.instruction[24:20];
  assign funct7 = bus.instruction[31:25];

  logic rd_ok, rs1_ok, rs2_ok;
  assign rd_ok  = {1'b0, rd}  < NREG;
  assign rs1_ok = {1'b0, rs1} < NREG;
  assign rs2_ok = {1'b0, rs2} < NREG;

  logic is_ialu, is_ralu, is_lw, is_sw, is_nop, is_mem, static_ok;
  logic ialu_fn_ok, ralu_fn_ok;

  // Shift-immediates carry their function selector in funct7; the rest ignore it.
  always_comb begin
    ialu_fn_ok = 1'b1;
    if (funct3 == 3'b001) ialu_fn_ok = (funct7 == 7'b0000000);
    else if (funct3 == 3'b101) ialu_fn_ok = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
  end

  always_comb begin
    ralu_fn_ok = 1'b0;
    if (funct7 == 7'b0000000) ralu_fn_ok = 1'b1;
    else if (funct7 == 7'b0100000) ralu_fn_ok = (funct3 == 3'b000) || (funct3 == 3'b101);
    else if (funct7 == 7'b0000001) ralu_fn_ok = ENABLE_MUL && !funct3[2];
  end

  assign is_ialu = (opcode == 7'b0010011) && ialu_fn_ok && rs1_ok && rd_ok;
  assign is_ralu = (opcode == 7'b0110011) && ralu_fn_ok && rs1_ok && rs2_ok && rd_ok;
  assign is_lw   = ENABLE_LW && (opcode == 7'b0000011) && (funct3 == 3'b010) &&
                   (rs1 == 5'd0) && (bus.instruction[31:30] == 2'b00) && rd_ok;
  assign is_sw   = (opcode == 7'b0100011) && (funct3 == 3'b010) &&
                   (rs1 == 5'd0) && (bus.instruction[31:30] == 2'b00) && rs2_ok;
  assign is_nop  = (opcode == 7'b1111111);
  assign is_mem  = is_lw || is_sw;
  assign static_ok = is_ialu || is_ralu || is_mem || is_nop;

  logic exhausted, mem_ok, allowed, accept;
  assign exhausted = (inst_count_q == INST_W'(MAX_INSTS));
  assign mem_ok    = (mem_count_q < MEM_W'(MAX_MEM_OPS)) && (gap_q == '0);
  assign allowed   = static_ok && (is_nop || (!exhausted && (!is_mem || mem_ok)));
  assign accept    = bus.inst_valid && allowed && !rst;

  always_comb begin
    inst_count_d = inst_count_q;
    mem_count_d  = mem_count_q;
    gap_d        = gap_q;
    violation_d  = bus.inst_valid && !allowed && !rst;
    if (accept) begin
      if (!is_nop) inst_count_d = inst_count_q + INST_W'(1);
      if (is_mem) begin
        mem_count_d = mem_count_q + MEM_W'(1);
        gap_d       = GAP_W'(MEM_GAP);
      end else if (gap_q != '0) begin
        gap_d = gap_q - GAP_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      inst_count_q <= '0;
      mem_count_q  <= '0;
      gap_q        <= '0;
      violation_q  <= 1'b0;
    end else begin
      inst_count_q <= inst_count_d;
      mem_count_q  <= mem_count_d;
      gap_q        <= gap_d;
      violation_q  <= violation_d;
    end
  end

  phase_e phase;
  always_comb begin
    phase = PH_RUN;
    if (exhausted) phase = PH_DRAIN;
    else if (gap_q != '0) phase = PH_COOLDOWN;
  end

  assign bus.allowed    = allowed;
  assign bus.phase      = phase;
  assign bus.inst_count = inst_count_q;
  assign bus.mem_count  = mem_count_q;
  assign bus.violation  = violation_q;

  generate
    if (ASSUME_EN) begin : g_assume
      assume property (@(posedge clk) rst || !bus.inst_valid || bus.allowed);
    end
  endgenerate
endmodule

// File: tb/tb_qed_inst_constraint_seq.sv
// Two differently-configured constraint instances share one stimulus stream and are
// each compared against a rule-level model every cycle.
module tb_qed_inst_constraint_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // A: 16 regs, no MUL, tiny budget, gap 2.  B: 8 regs, MUL, gap 0, two mem ops.
  qed_inst_constraint_seq_if #(.MAX_INSTS(3),  .MAX_MEM_OPS(4)) a_if ();
  qed_inst_constraint_seq_if #(.MAX_INSTS(20), .MAX_MEM_OPS(2)) b_if ();

  qed_inst_constraint_seq #(
    .NUM_ORIG_REGS(16), .ENABLE_MUL(1'b0), .ENABLE_LW(1'b1), .MAX_INSTS(3),
    .MAX_MEM_OPS(4), .MEM_GAP(2), .ASSUME_EN(1'b0)
  ) dut_a (.clk(clk), .rst(rst), .bus(a_if.slave));

  qed_inst_constraint_seq #(
    .NUM_ORIG_REGS(8), .ENABLE_MUL(1'b1), .ENABLE_LW(1'b1), .MAX_INSTS(20),
    .MAX_MEM_OPS(2), .MEM_GAP(0), .ASSUME_EN(1'b0)
  ) dut_b (.clk(clk), .rst(rst), .bus(b_if.slave));

  int checks = 0;
  int failures = 0;
  int step_no = 0;

  int cfg_regs[2]  = '{16, 8};
  bit cfg_mul[2]   = '{1'b0, 1'b1};
  int cfg_maxi[2]  = '{3, 20};
  int cfg_maxm[2]  = '{4, 2};
  int cfg_gap[2]   = '{2, 0};
  int m_cnt[2], m_mem[2], m_gap[2];
  bit m_viol[2];

  localparam logic [31:0] ADDI_OK  = 32'h00510093;  // addi x1,x2,5
  localparam logic [31:0] ADDI_X17 = 32'h00510893;  // addi x17,x2,5
  localparam logic [31:0] MUL_I    = 32'h023100B3;  // mul x1,x2,x3
  localparam logic [31:0] ADD_X9   = 32'h002084B3;  // add x9,x1,x2
  localparam logic [31:0] ADD_I    = 32'h002081B3;  // add x3,x1,x2
  localparam logic [31:0] SW_I     = 32'h00102023;  // sw x1,0(x0)
  localparam logic [31:0] LW_I     = 32'h00002083;  // lw x1,0(x0)
  localparam logic [31:0] NOP_I    = 32'h0000007F;

  function automatic bit legal(input logic [31:0] i, input int d);
    int op = int'(i[6:0]);
    int f3 = int'(i[14:12]);
    int f7 = int'(i[31:25]);
    int rd = int'(i[11:7]);
    int r1 = int'(i[19:15]);
    int r2 = int'(i[24:20]);
    int n  = cfg_regs[d];
    case (op)
      'h13: begin
        if (rd >= n || r1 >= n) return 1'b0;
        if (f3 == 1) return f7 == 0;
        if (f3 == 5) return (f7 == 0) || (f7 == 'h20);
        return 1'b1;
      end
      'h33: begin
        if (rd >= n || r1 >= n || r2 >= n) return 1'b0;
        if (f7 == 0) return 1'b1;
        if (f7 == 'h20) return (f3 == 0) || (f3 == 5);
        if (f7 == 1) return cfg_mul[d] && (f3 <= 3);
        return 1'b0;
      end
      'h03: return (f3 == 2) && (r1 == 0) && (i[31:30] == 2'b00) && (rd < n);
      'h23: return (f3 == 2) && (r1 == 0) && (i[31:30] == 2'b00) && (r2 < n);
      'h7F: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic bit is_mem_op(input logic [31:0] i);
    return (i[6:0] == 7'h03) || (i[6:0] == 7'h23);
  endfunction

  function automatic bit exp_allowed(input logic [31:0] i, input int d);
    if (!legal(i, d)) return 1'b0;
    if (i[6:0] == 7'h7F) return 1'b1;
    if (m_cnt[d] >= cfg_maxi[d]) return 1'b0;
    if (is_mem_op(i)) return (m_mem[d] < cfg_maxm[d]) && (m_gap[d] == 0);
    return 1'b1;
  endfunction

  function automatic int exp_phase(input int d);
    if (m_cnt[d] == cfg_maxi[d]) return 2;
    if (m_gap[d] != 0) return 1;
    return 0;
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s step=%0d observed=%0d expected=%0d", tag, step_no, obs, exp);
    end
  endtask

  task automatic check_outputs(input logic [31:0] ins);
    chk("a_allowed",    int'(a_if.allowed),    int'(exp_allowed(ins, 0)));
    chk("a_phase",      int'(a_if.phase),      exp_phase(0));
    chk("a_inst_count", int'(a_if.inst_count), m_cnt[0]);
    chk("a_mem_count",  int'(a_if.mem_count),  m_mem[0]);
    chk("a_violation",  int'(a_if.violation),  int'(m_viol[0]));
    chk("b_allowed",    int'(b_if.allowed),    int'(exp_allowed(ins, 1)));
    chk("b_phase",      int'(b_if.phase),      exp_phase(1));
    chk("b_inst_count", int'(b_if.inst_count), m_cnt[1]);
    chk("b_mem_count",  int'(b_if.mem_count),  m_mem[1]);
    chk("b_violation",  int'(b_if.violation),  int'(m_viol[1]));
  endtask

  task automatic model_update(input logic [31:0] ins, input bit v, input bit r);
    for (int d = 0; d < 2; d++) begin
      bit ok = exp_allowed(ins, d);
      if (r) begin
        m_cnt[d] = 0; m_mem[d] = 0; m_gap[d] = 0; m_viol[d] = 1'b0;
      end else begin
        m_viol[d] = v && !ok;
        if (v && ok) begin
          if (ins[6:0] != 7'h7F) m_cnt[d]++;
          if (is_mem_op(ins)) begin
            m_mem[d]++;
            m_gap[d] = cfg_gap[d];
          end else if (m_gap[d] > 0) begin
            m_gap[d]--;
          end
        end
      end
    end
  endtask

  task automatic step(input logic [31:0] ins, input bit v, input bit r);
    @(negedge clk);
    step_no++;
    a_if.instruction = ins; a_if.inst_valid = v;
    b_if.instruction = ins; b_if.inst_valid = v;
    rst = r;
    #1;
    check_outputs(ins);
    $display("step %0d rst=%0b valid=%0b ins=%08h allowed a/b=%0b/%0b", step_no, r, v, ins,
             a_if.allowed, b_if.allowed);
    model_update(ins, v, r);
  endtask

  function automatic logic [4:0] rand_reg();
    if ($urandom_range(0, 3) == 0) return 5'($urandom_range(0, 31));
    return 5'($urandom_range(0, 9));
  endfunction

  function automatic logic [31:0] rand_inst();
    logic [31:0] i = $urandom;
    logic [6:0] f7;
    case ($urandom_range(0, 6))
      0: i[6:0] = 7'h13;
      1, 2: begin
        i[6:0] = 7'h33;
        case ($urandom_range(0, 3))
          0: f7 = 7'h00;
          1: f7 = 7'h20;
          2: f7 = 7'h01;
          default: f7 = 7'($urandom);
        endcase
        i[31:25] = f7;
      end
      3: begin i[6:0] = 7'h03; i[14:12] = 3'b010; i[19:15] = 5'd0; i[31:30] = 2'b00; end
      4: begin i[6:0] = 7'h23; i[14:12] = 3'b010; i[19:15] = 5'd0; i[31:30] = 2'b00; end
      5: i[6:0] = 7'h7F;
      default: ;
    endcase
    if (i[6:0] == 7'h13 && $urandom_range(0, 1) == 1) i[31:25] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
    if (i[6:0] != 7'h7F) begin
      i[11:7]  = rand_reg();
      i[24:20] = rand_reg();
      if (i[6:0] == 7'h13 || i[6:0] == 7'h33) i[19:15] = rand_reg();
      else if ($urandom_range(0, 7) == 0) i[19:15] = 5'd1;
    end
    return i;
  endfunction

  initial begin
    for (int d = 0; d < 2; d++) begin
      m_cnt[d] = 0; m_mem[d] = 0; m_gap[d] = 0; m_viol[d] = 1'b0;
    end
    a_if.instruction = '0; a_if.inst_valid = 1'b0;
    b_if.instruction = '0; b_if.inst_valid = 1'b0;

    step(ADDI_X17, 1'b1, 1'b1);
    step(ADDI_X17, 1'b1, 1'b1);
    step(ADDI_OK,  1'b1, 1'b0);
    step(ADDI_X17, 1'b1, 1'b0);
    step(MUL_I,    1'b1, 1'b0);
    step(ADD_X9,   1'b1, 1'b0);
    step(ADDI_X17, 1'b0, 1'b0);
    step(ADD_I,    1'b1, 1'b0);
    step(NOP_I,    1'b1, 1'b0);

    step(NOP_I,    1'b0, 1'b1);
    step(SW_I,     1'b1, 1'b0);
    step(LW_I,     1'b1, 1'b0);
    step(NOP_I,    1'b1, 1'b0);
    step(ADDI_OK,  1'b1, 1'b0);
    step(LW_I,     1'b1, 1'b0);
    step(SW_I,     1'b1, 1'b0);
    step(ADD_I,    1'b1, 1'b0);
    step(NOP_I,    1'b1, 1'b0);
    step(ADD_I,    1'b1, 1'b1);
    step(ADDI_X17, 1'b0, 1'b0);
    step(ADDI_X17, 1'b0, 1'b0);

    step(SW_I,     1'b1, 1'b0);
    step(SW_I,     1'b1, 1'b0);
    step(SW_I,     1'b1, 1'b0);
    step(NOP_I,    1'b0, 1'b0);

    for (int n = 0; n < 400; n++) begin
      step(rand_inst(), ($urandom_range(0, 4) != 0), ($urandom_range(0, 24) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
